// File: rtl/dual_slave_onchip_memory.sv
// dual_slave_onchip_memory
// Shared word-addressed RAM behind two Avalon-MM slaves (s1, s2). One RAM port
// is shared through a round-robin arbiter. Reads are pipelined with
// READ_LATENCY 1 or 2. Out-of-range accesses are accepted, but writes are
// dropped and reads return zero.
// Optional zeroize engine: define DUAL_SLAVE_MEM_ZEROIZE_EN to build it.
module dual_slave_onchip_memory #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 14,
    parameter int DEPTH        = 12500,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    reset_req,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest,
    input  logic                    zeroize,
    output logic                    zeroize_busy
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  w_en, w_busy, w_active;
    logic                  w_req1, w_req2, w_gnt1, w_gnt2, w_acc, w_rd_acc;
    logic                  r_last_grant;              // 1 = s2 granted last
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_wr, w_in_range;
    logic [BE_W-1:0]       w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_zero_we;
    logic [IDX_W-1:0]      w_zero_idx;
    logic                  w_ram_we;
    logic [IDX_W-1:0]      w_ram_idx;
    logic [BE_W-1:0]       w_ram_be;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_ram_q;
    logic                  r_v1, r_p1, r_oor1;
    logic [DATA_WIDTH-1:0] w_d1;
    logic                  w_out_v, w_out_p;
    logic [DATA_WIDTH-1:0] w_out_d;
    logic [DATA_WIDTH-1:0] r_hold1, r_hold2;

    // The pipeline and zeroize engine advance on w_en; new requests also need the engine idle.
    assign w_en         = clken & ~reset_req;
    assign w_active     = w_en & ~w_busy;
    assign zeroize_busy = w_busy;

    // Round-robin: on a tie the port not granted last wins.
    assign w_req1 = s1_chipselect & (s1_read | s1_write);
    assign w_req2 = s2_chipselect & (s2_read | s2_write);
    assign w_gnt1 = w_req1 & (~w_req2 | r_last_grant);
    assign w_gnt2 = w_req2 & ~w_gnt1;
    assign s1_waitrequest = w_req1 & ~(w_gnt1 & w_active);
    assign s2_waitrequest = w_req2 & ~(w_gnt2 & w_active);
    assign w_acc    = (w_gnt1 | w_gnt2) & w_active;

    // Granted-port mux; read+write together counts as a write.
    assign w_addr     = w_gnt2 ? s2_address    : s1_address;
    assign w_wr       = w_gnt2 ? s2_write      : s1_write;
    assign w_be       = w_gnt2 ? s2_byteenable : s1_byteenable;
    assign w_wdata    = w_gnt2 ? s2_writedata  : s1_writedata;
    assign w_in_range = {1'b0, w_addr} < DEPTH_L;
    assign w_idx      = w_addr[IDX_W-1:0];
    assign w_rd_acc   = w_acc & ~w_wr;

    // Track the last accepted port; s2 after reset so s1 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   r_last_grant <= 1'b1;
        else if (w_acc) r_last_grant <= w_gnt2;
    end

    // Zeroize and bus writes never coincide because the engine blocks acceptance.
    assign w_ram_we    = w_zero_we | (w_acc & w_wr & w_in_range);
    assign w_ram_idx   = w_zero_we ? w_zero_idx : w_idx;
    assign w_ram_be    = w_zero_we ? '1 : w_be;
    assign w_ram_wdata = w_zero_we ? '0 : w_wdata;

    // RAM array: byte-lane writes and registered read, no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (w_ram_be[i]) r_mem[w_ram_idx][i*8 +: 8] <= w_ram_wdata[i*8 +: 8];
            end
        end
        if (w_rd_acc) r_ram_q <= r_mem[w_idx];
    end

    // Stage 1 read tag: valid, owning port and out-of-range mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1   <= 1'b0;
            r_p1   <= 1'b0;
            r_oor1 <= 1'b0;
        end else if (w_en) begin
            r_v1   <= w_rd_acc;
            r_p1   <= w_gnt2;
            r_oor1 <= ~w_in_range;
        end
    end

    assign w_d1 = r_oor1 ? '0 : r_ram_q;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_v2, r_p2;
            logic [DATA_WIDTH-1:0] r_d2;
            // Stage 2 output register.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_v2 <= 1'b0;
                    r_p2 <= 1'b0;
                    r_d2 <= '0;
                end else if (w_en) begin
                    r_v2 <= r_v1;
                    r_p2 <= r_p1;
                    r_d2 <= w_d1;
                end
            end
            assign w_out_v = r_v2;
            assign w_out_p = r_p2;
            assign w_out_d = r_d2;
        end else begin : g_lat1
            assign w_out_v = r_v1;
            assign w_out_p = r_p1;
            assign w_out_d = w_d1;
        end
    endgenerate

    assign s1_readdatavalid = w_out_v & ~w_out_p;
    assign s2_readdatavalid = w_out_v & w_out_p;
    assign s1_readdata      = s1_readdatavalid ? w_out_d : r_hold1;
    assign s2_readdata      = s2_readdatavalid ? w_out_d : r_hold2;

    // Per-port shadow so readdata holds its last value between valids.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold1 <= '0;
            r_hold2 <= '0;
        end else begin
            if (s1_readdatavalid) r_hold1 <= w_out_d;
            if (s2_readdatavalid) r_hold2 <= w_out_d;
        end
    end

`ifdef DUAL_SLAVE_MEM_ZEROIZE_EN
    logic             r_zbusy;
    logic [IDX_W-1:0] r_zcnt;

    // Zeroize engine: one zero word per enabled cycle over 0..DEPTH-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_zbusy <= 1'b0;
            r_zcnt  <= '0;
        end else if (w_en) begin
            if (!r_zbusy) begin
                if (zeroize) begin
                    r_zbusy <= 1'b1;
                    r_zcnt  <= '0;
                end
            end else if (r_zcnt == IDX_W'(DEPTH - 1)) begin
                r_zbusy <= 1'b0;
            end else begin
                r_zcnt <= r_zcnt + 1'b1;
            end
        end
    end

    assign w_busy     = r_zbusy;
    assign w_zero_we  = r_zbusy & w_en;
    assign w_zero_idx = r_zcnt;
`else
    logic w_unused_zeroize;
    assign w_unused_zeroize = zeroize;
    assign w_busy           = 1'b0;
    assign w_zero_we        = 1'b0;
    assign w_zero_idx       = '0;
`endif

endmodule

// File: doc/dual_slave_onchip_memory.md
Name: dual_slave_onchip_memory

Overview:
Parametrised on-chip RAM for the red/black data path. It generalises the fixed 32x12500 single-slave memory to configurable width and depth, and adds a second Avalon-MM slave port (s2) that shares one RAM port through a round-robin arbiter. It also adds waitrequest/readdatavalid pipelined reads with selectable latency and out-of-range protection. It sits between the red-side and black-side masters as the shared buffer memory.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 14, word address width of both slaves.
DEPTH, 12500, number of words implemented; must be ≤ 2**ADDR_WIDTH.
READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values 1 (unregistered output) or 2 (registered output).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clken  in  1  global clock enable; 0 stalls all state
reset_req  in  1  reset request; 1 behaves as clken=0
s1_address  in  ADDR_WIDTH  slave 1 word address
s1_chipselect  in  1  slave 1 select
s1_read  in  1  slave 1 read request
s1_write  in  1  slave 1 write request
s1_byteenable  in  DATA_WIDTH/8  slave 1 byte lanes
s1_writedata  in  DATA_WIDTH  slave 1 write data
s1_readdata  out  DATA_WIDTH  slave 1 read data
s1_readdatavalid  out  1  slave 1 read data qualifier
s1_waitrequest  out  1  slave 1 stall
s2_*  (same set as s1_*)  slave 2
zeroize  in  1  zeroize request pulse (see Optional Feature)
zeroize_busy  out  1  zeroize in progress

Behaviour:
- Request on port n: chipselect & (read | write). A request with both read and write set is treated as a write.
- Enable: active = clken & ~reset_req & ~zeroize_busy. When active=0, no request is accepted, both waitrequests equal their request, and the read pipeline holds.
- Arbitration: if only one port requests, it is granted. If both request, the port not granted last is granted. The last_grant register updates only on an accepted request and resets to s2, so s1 wins the first tie.
- waitrequest_n = request_n & ~(grant_n & active). This is combinational. waitrequest=0 when the port is idle.
- Write: on accept, each byte lane with byteenable=1 is written in the same cycle. Lanes with byteenable=0 are preserved. byteenable=0 on all lanes is a legal no-op.
- Read: on accept, the RAM is read in the same cycle. readdatavalid is asserted on the requesting port exactly READ_LATENCY enabled cycles later, for one cycle, with readdata. Reads complete in order, one per cycle maximum across both ports.
- readdata is held at its last value when readdatavalid=0.
- Out of range (address ≥ DEPTH): the request is accepted normally. A write is dropped. A read returns all zeros with normal readdatavalid timing.
- Ordering: a write accepted the cycle after a read to the same address does not affect that read, which returns old data.
- Reset (asynchronous, reset_n=0):
  - readdata, readdatavalid and zeroize_busy go to 0.
  - The pipeline is flushed; in-flight reads are dropped with no readdatavalid.
  - last_grant goes to s2.
  - RAM contents are not reset.
- Release: reset_n is de-asserted synchronously by the system reset synchroniser.

Optional Feature:
Macro: DUAL_SLAVE_MEM_ZEROIZE_EN
- Defined:
  - A zeroize=1 sample while not busy sets zeroize_busy=1 on the next clock.
  - An address counter then writes all-zero data to words 0..DEPTH-1, one word per clken & ~reset_req cycle.
  - zeroize_busy clears in the cycle after word DEPTH-1 is written.
  - Reads already in the pipeline complete normally. New requests see waitrequest=1 throughout.
  - zeroize while busy is ignored.
  - reset_n during zeroize aborts it, leaving memory partially cleared.
- Undefined: the zeroize input is ignored, zeroize_busy is tied to 0, and no counter is built.

Test Plan:
- s1 writes 0xDEADBEEF to addr 5 with be=4'hF, then s1 reads addr 5 → s1_readdatavalid 1 cycle after accept (READ_LATENCY=1) with 0xDEADBEEF, s1_waitrequest=0 both cycles.
- s2 writes 0x11223344 to addr 7 with be=4'b0101 over existing 0xAABBCCDD → a read of addr 7 returns 0xAA22CC44.
- s1 and s2 request reads simultaneously for 4 cycles → grants alternate s1, s2, s1, s2, the loser sees waitrequest=1 in each cycle, and four readdatavalids appear in grant order.
- READ_LATENCY=2, with clken=0 for 3 cycles in the middle of a read → readdatavalid is delayed by exactly 3 cycles and data is unchanged; reset_req=1 gives the same result.
- Read addr 12500 (DEPTH=12500) → readdata=0 with valid; write addr 12600 → no RAM word changes (check words 0 and 12499).
- With the macro defined, fill words with 0xFFFFFFFF, pulse zeroize → busy for 12500 cycles, s1 waitrequest=1 throughout, then all words read 0. A second run with reset_n=0 at cycle 100 gives words ≥100 still 0xFFFFFFFF and busy=0.
